fetch_prefetch_queue: RTL



---
 rtl/fetch_prefetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - prefetching fetch stage with DEPTH-entry queue and one outstanding memory read
// Redirect flushes the queue; a request still in flight is tracked and its response dropped.
module fetch_prefetch_queue #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 16,
  parameter int                 DEPTH     = 4,
  parameter int                 PC_INCR   = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(16'h0800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_err,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] next_pc,
  output logic              err,
  output logic              stall_out
);

  localparam int                PW   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);
  localparam logic [PW:0]       FULL = (PW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_addr;
  logic              busy;
  logic              drop;
  logic              err_q;
  logic              stall_q;

  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_npc   [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic can_issue;
  logic issue;
  logic done;
  logic enq;
  logic deq;

  // mem_addr comes from req_addr while busy so a redirect cannot disturb a pending read
  assign can_issue = ~busy & ~halt & ~err_q & (count < FULL) & ~redirect;
  assign mem_rd    = ~rst & (busy | can_issue);
  assign mem_addr  = busy ? req_addr : fpc;
  assign issue     = mem_rd & ~busy;
  assign done      = mem_rd & mem_done;
  assign enq       = done & ~drop & ~redirect;
  assign deq       = (count != '0) & ~stall & ~redirect;

  assign instr_valid = (count != '0) & ~redirect;
  assign instr       = instr_valid ? q_instr[head] : NOP_INSTR;
  assign next_pc     = q_npc[head];
  assign err         = err_q;
  assign stall_out   = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      busy     <= 1'b0;
      drop     <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= NOP_INSTR;
        q_npc[i]   <= '0;
      end
    end else begin
      stall_q <= mem_stall;

      if (mem_rd & mem_err) begin
        err_q <= 1'b1;
      end

      if (done) begin
        busy <= 1'b0;
      end else if (issue) begin
        busy     <= 1'b1;
        req_addr <= fpc;
      end

      if (redirect & busy & ~mem_done) begin
        drop <= 1'b1;
      end else if (done) begin
        drop <= 1'b0;
      end

      if (redirect) begin
        fpc <= redirect_pc;
      end else if (enq) begin
        fpc <= fpc + INCR;
      end

      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          q_instr[tail] <= mem_data;
          q_npc[tail]   <= fpc + INCR;
          tail          <= tail + 1'b1;
        end
        if (deq) begin
          head <= head + 1'b1;
        end
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
